// File: rtl/mod_raise_bba_to_qbba_pkg.sv
// Shared RNS types, basis constants and fast-base-conversion tables for the BBa -> qBBa raise.
`ifndef N_SLOTS
`define N_SLOTS 2
`endif
`ifndef q_BASIS_LEN
`define q_BASIS_LEN 2
`endif
`ifndef BBa_BASIS_LEN
`define BBa_BASIS_LEN 3
`endif
`ifndef qBBa_BASIS_LEN
`define qBBa_BASIS_LEN 5
`endif
`ifndef RNS_PRIME_BITS
`define RNS_PRIME_BITS 5
`endif

package mod_raise_bba_to_qbba_pkg;

    localparam int unsigned NSlots    = `N_SLOTS;
    localparam int unsigned QLen      = `q_BASIS_LEN;
    localparam int unsigned BbaLen    = `BBa_BASIS_LEN;
    localparam int unsigned QbbaLen   = `qBBa_BASIS_LEN;
    localparam int unsigned PrimeBits = `RNS_PRIME_BITS;

    // Cycles from fastBConv in_valid to its out_valid.
    localparam int unsigned FbcLatency = 2;

    typedef logic [PrimeBits-1:0] rns_residue_t;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} raise_state_e;

    localparam int unsigned q_BASIS   [QLen]   = '{17, 19};
    localparam int unsigned BBa_BASIS [BbaLen] = '{23, 29, 31};

    // M_BBa = 20677; z[j] = (M_BBa/BBa_j)^-1 mod BBa_j
    localparam int unsigned z_MOD_BBa [BbaLen] = '{12, 12, 2};

    // y[j][i] = (M_BBa/BBa_j) mod q_i
    localparam int unsigned y_BBa_TO_q [BbaLen][QLen] = '{'{15, 6}, '{16, 10}, '{4, 2}};

endpackage

// File: rtl/mod_raise_bba_to_qbba_fastbconv.sv
// Two-stage fast base conversion: scale each input residue by its z LUT entry, then
// accumulate against the y LUT and reduce modulo each output prime.
module fastBConv
    import mod_raise_bba_to_qbba_pkg::*;
#(
    parameter int unsigned SLOTS                        = NSlots,
    parameter int unsigned IN_LEN                       = BbaLen,
    parameter int unsigned OUT_LEN                      = QLen,
    parameter int unsigned IN_BASIS  [IN_LEN]           = BBa_BASIS,
    parameter int unsigned OUT_BASIS [OUT_LEN]          = q_BASIS,
    parameter int unsigned ZiLUT     [IN_LEN]           = z_MOD_BBa,
    parameter int unsigned YMODB     [IN_LEN][OUT_LEN]  = y_BBa_TO_q
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  rns_residue_t in_res  [SLOTS][IN_LEN],
    output logic         out_valid,
    output rns_residue_t out_res [SLOTS][OUT_LEN]
);

    rns_residue_t a_d   [SLOTS][IN_LEN];
    rns_residue_t a_q   [SLOTS][IN_LEN];
    rns_residue_t res_d [SLOTS][OUT_LEN];
    rns_residue_t res_q [SLOTS][OUT_LEN];
    logic         s1_valid_q;
    logic         out_valid_q;

    always_comb begin
        for (int k = 0; k < int'(SLOTS); k++) begin
            for (int j = 0; j < int'(IN_LEN); j++) begin
                a_d[k][j] = rns_residue_t'((32'(in_res[k][j]) * ZiLUT[j]) % IN_BASIS[j]);
            end
        end
    end

    always_comb begin
        int unsigned acc;
        acc = 0;
        for (int k = 0; k < int'(SLOTS); k++) begin
            for (int i = 0; i < int'(OUT_LEN); i++) begin
                acc = 0;
                for (int j = 0; j < int'(IN_LEN); j++) begin
                    acc = acc + 32'(a_q[k][j]) * YMODB[j][i];
                end
                res_d[k][i] = rns_residue_t'(acc % OUT_BASIS[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '{default: '0};
            res_q       <= '{default: '0};
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (in_valid) begin
                a_q <= a_d;
            end
            if (s1_valid_q) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = res_q;

endmodule

// File: rtl/mod_raise_bba_to_qbba.sv
// Extends BBa-basis RNS slots to the full qBBa basis: q residues come from fastBConv,
// BBa residues pass through from the accepted input.
module mod_raise_bba_to_qbba
    import mod_raise_bba_to_qbba_pkg::*;
#(
    parameter int unsigned IN_BASIS_LEN  = BbaLen,
    parameter int unsigned OUT_BASIS_LEN = QbbaLen
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  rns_residue_t input_RNSpoly  [NSlots][IN_BASIS_LEN],
    output logic         out_valid,
    output rns_residue_t output_RNSpoly [NSlots][OUT_BASIS_LEN],
    output logic         busy
);

    localparam int unsigned QL = OUT_BASIS_LEN - IN_BASIS_LEN;

    raise_state_e state_d, state_q;
    rns_residue_t latch_d [NSlots][IN_BASIS_LEN];
    rns_residue_t latch_q [NSlots][IN_BASIS_LEN];
    rns_residue_t out_d   [NSlots][OUT_BASIS_LEN];
    rns_residue_t out_q   [NSlots][OUT_BASIS_LEN];
    rns_residue_t fbc_res [NSlots][QL];
    logic         fbc_in_valid;
    logic         fbc_out_valid;

    fastBConv #(
        .SLOTS     (NSlots),
        .IN_LEN    (IN_BASIS_LEN),
        .OUT_LEN   (QL),
        .IN_BASIS  (BBa_BASIS),
        .OUT_BASIS (q_BASIS),
        .ZiLUT     (z_MOD_BBa),
        .YMODB     (y_BBa_TO_q)
    ) u_fbc (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fbc_in_valid),
        .in_res    (latch_q),
        .out_valid (fbc_out_valid),
        .out_res   (fbc_res)
    );

    always_comb begin
        state_d      = state_q;
        latch_d      = latch_q;
        out_d        = out_q;
        fbc_in_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    latch_d = input_RNSpoly;
                    state_d = StStart;
                end
            end
            StStart: begin
                fbc_in_valid = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                if (fbc_out_valid) begin
                    for (int k = 0; k < int'(NSlots); k++) begin
                        for (int i = 0; i < int'(QL); i++) begin
                            out_d[k][i] = fbc_res[k][i];
                        end
                        for (int j = 0; j < int'(IN_BASIS_LEN); j++) begin
                            out_d[k][QL+j] = latch_q[k][j];
                        end
                    end
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            latch_q <= '{default: '0};
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            out_q   <= out_d;
        end
    end

    assign in_ready       = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign out_valid      = (state_q == StDone);
    assign output_RNSpoly = out_q;

endmodule

// File: tb/tb_mod_raise_bba_to_qbba.sv
// Randomized bench for the BBa -> qBBa raise against a CRT-sum reference model.
module tb_mod_raise_bba_to_qbba;
    import mod_raise_bba_to_qbba_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic busy;
    rns_residue_t input_RNSpoly  [NSlots][BbaLen];
    rns_residue_t output_RNSpoly [NSlots][QbbaLen];

    rns_residue_t exp_out [NSlots][QbbaLen];
    rns_residue_t exp_a   [NSlots][QbbaLen];
    rns_residue_t exp_b   [NSlots][QbbaLen];
    rns_residue_t data_a  [NSlots][BbaLen];
    rns_residue_t data_b  [NSlots][BbaLen];
    longint unsigned exp_x [NSlots];
    longint unsigned m_bba;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_raise_bba_to_qbba dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .input_RNSpoly  (input_RNSpoly),
        .out_valid      (out_valid),
        .output_RNSpoly (output_RNSpoly),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact CRT: s = sum_j ((x_j * inv_j) mod b_j) * (M/b_j); q residues are s mod q_i.
    task automatic model();
        m_bba = 1;
        for (int j = 0; j < int'(BbaLen); j++) m_bba = m_bba * longint'(BBa_BASIS[j]);
        for (int k = 0; k < int'(NSlots); k++) begin
            longint unsigned s;
            s = 0;
            for (int j = 0; j < int'(BbaLen); j++) begin
                longint unsigned b, mj, inv;
                b   = longint'(BBa_BASIS[j]);
                mj  = m_bba / b;
                inv = 0;
                for (longint unsigned t = 1; t < b; t++) if (((mj % b) * t) % b == 1) inv = t;
                s = s + (((longint'(input_RNSpoly[k][j]) * inv) % b) * mj);
            end
            exp_x[k] = s % m_bba;
            for (int i = 0; i < int'(QLen); i++)
                exp_out[k][i] = rns_residue_t'(s % longint'(q_BASIS[i]));
            for (int j = 0; j < int'(BbaLen); j++) exp_out[k][QLen+j] = input_RNSpoly[k][j];
        end
    endtask

    task automatic rand_input();
        for (int k = 0; k < int'(NSlots); k++)
            for (int j = 0; j < int'(BbaLen); j++)
                input_RNSpoly[k][j] = rns_residue_t'($urandom_range(BBa_BASIS[j] - 1, 0));
    endtask

    task automatic fill_input(input int v);
        for (int k = 0; k < int'(NSlots); k++)
            for (int j = 0; j < int'(BbaLen); j++) input_RNSpoly[k][j] = rns_residue_t'(v);
    endtask

    function automatic int out_diff();
        int n = 0;
        for (int k = 0; k < int'(NSlots); k++)
            for (int i = 0; i < int'(QbbaLen); i++)
                if (output_RNSpoly[k][i] !== exp_out[k][i]) n++;
        return n;
    endfunction

    function automatic int nonzero();
        int n = 0;
        for (int k = 0; k < int'(NSlots); k++)
            for (int i = 0; i < int'(QbbaLen); i++)
                if (output_RNSpoly[k][i] !== '0) n++;
        return n;
    endfunction

    function automatic int range_viol();
        int n = 0;
        for (int k = 0; k < int'(NSlots); k++) begin
            for (int i = 0; i < int'(QLen); i++)
                if (32'(output_RNSpoly[k][i]) >= q_BASIS[i]) n++;
            for (int j = 0; j < int'(BbaLen); j++)
                if (32'(output_RNSpoly[k][QLen+j]) >= BBa_BASIS[j]) n++;
        end
        return n;
    endfunction

    // Slots whose q part is not (x + u*M) mod q_i for one shared u in [0, BbaLen-1].
    function automatic int u_bad();
        int n = 0;
        for (int k = 0; k < int'(NSlots); k++) begin
            bit ok = 1'b0;
            for (int u = 0; u < int'(BbaLen); u++) begin
                bit match = 1'b1;
                for (int i = 0; i < int'(QLen); i++)
                    if (longint'(output_RNSpoly[k][i]) !=
                        (exp_x[k] + longint'(u) * m_bba) % longint'(q_BASIS[i])) match = 1'b0;
                if (match) ok = 1'b1;
            end
            if (!ok) n++;
        end
        return n;
    endfunction

    // Accept at cycle 0; returns the out_valid cycle (-1 if none) and pulse width.
    task automatic run_txn(output int lat, output int width);
        lat   = -1;
        width = 0;
        in_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            in_valid = 1'b0;
            if (out_valid) begin
                if (lat < 0) lat = c;
                width++;
            end else if (lat >= 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        rand_input();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            checks++; if (nonzero() !== 0) begin errors++; $display("FAIL reset_output: %0d nonzero residues, want 0", nonzero()); end
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept: busy %b want 0", busy); end
    endtask

    task automatic test_zero();
        int lat, width;
        fill_input(0);
        model();
        run_txn(lat, width);
        checks++; if (lat !== int'(FbcLatency) + 2) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, FbcLatency + 2); end
        checks++; if (width !== 1) begin errors++; $display("FAIL zero_pulse_width: got %0d want 1", width); end
        checks++; if (nonzero() !== 0) begin errors++; $display("FAIL zero_output: %0d nonzero residues, want 0", nonzero()); end
    endtask

    task automatic test_ones();
        int lat, width;
        fill_input(1);
        model();
        run_txn(lat, width);
        checks++; if (lat !== int'(FbcLatency) + 2) begin errors++; $display("FAIL ones_latency: got %0d want %0d", lat, FbcLatency + 2); end
        checks++; if (out_diff() !== 0) begin errors++; $display("FAIL ones_output: %0d residues differ, want 0", out_diff()); end
        checks++; if (u_bad() !== 0) begin errors++; $display("FAIL ones_u_consistency: %0d slots bad, want 0", u_bad()); end
    endtask

    task automatic test_random();
        int lat, width;
        for (int n = 0; n < 6; n++) begin
            rand_input();
            model();
            run_txn(lat, width);
            checks++; if (lat !== int'(FbcLatency) + 2) begin errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", n, lat, FbcLatency + 2); end
            checks++; if (width !== 1) begin errors++; $display("FAIL random_pulse_width[%0d]: got %0d want 1", n, width); end
            checks++; if (out_diff() !== 0) begin errors++; $display("FAIL random_output[%0d]: %0d residues differ, want 0", n, out_diff()); end
            checks++; if (range_viol() !== 0) begin errors++; $display("FAIL random_range[%0d]: %0d residues out of range, want 0", n, range_viol()); end
            checks++; if (u_bad() !== 0) begin errors++; $display("FAIL random_u_consistency[%0d]: %0d slots bad, want 0", n, u_bad()); end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, acc2 = -1;
        rand_input(); data_a = input_RNSpoly; model(); exp_a = exp_out;
        rand_input(); data_b = input_RNSpoly; model(); exp_b = exp_out;
        input_RNSpoly = data_a;
        in_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) input_RNSpoly = data_b;
            if (out_valid) begin
                if (first < 0) begin
                    first = c;
                    exp_out = exp_a;
                    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL b2b_first_output: %0d residues differ, want 0", out_diff()); end
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b want 0", in_ready); end
                end else if (second < 0) begin
                    second = c;
                    exp_out = exp_b;
                    checks++; if (out_diff() !== 0) begin errors++; $display("FAIL b2b_second_output: %0d residues differ, want 0", out_diff()); end
                end
            end
            if (in_valid && in_ready && acc2 < 0) acc2 = c;
            else if (acc2 >= 0) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (first !== int'(FbcLatency) + 2) begin errors++; $display("FAIL b2b_first_cycle: got %0d want %0d", first, FbcLatency + 2); end
        checks++; if (acc2 !== int'(FbcLatency) + 3) begin errors++; $display("FAIL b2b_second_accept: got %0d want %0d", acc2, FbcLatency + 3); end
        checks++; if (second !== 2 * int'(FbcLatency) + 5) begin errors++; $display("FAIL b2b_second_cycle: got %0d want %0d", second, 2 * FbcLatency + 5); end
    endtask

    task automatic test_reset_in_wait();
        int seen = 0;
        int lat, width;
        rand_input();
        model();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wait_reset_ready: got %b want 1", in_ready); end
        checks++; if (nonzero() !== 0) begin errors++; $display("FAIL wait_reset_output: %0d nonzero residues, want 0", nonzero()); end
        if (out_valid) seen++;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL wait_reset_no_pulse: got %0d pulses want 0", seen); end
        rand_input();
        model();
        run_txn(lat, width);
        checks++; if (lat !== int'(FbcLatency) + 2) begin errors++; $display("FAIL wait_fresh_latency: got %0d want %0d", lat, FbcLatency + 2); end
        checks++; if (out_diff() !== 0) begin errors++; $display("FAIL wait_fresh_output: %0d residues differ, want 0", out_diff()); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        fill_input(0);
        test_reset();
        test_zero();
        test_ones();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
